player_state_engine: RTL



---
 rtl/player_state_engine_pkg.sv | 41 ++++
 rtl/player_input_latch.sv | 55 +++++
 rtl/player_state_engine.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/player_state_engine_pkg.sv
// Shared definitions for the per-player fighting-state engine.
// Holds the state encoding, button bit positions, width defaults and the
// button-priority resolver used when the player is free to start an action.
package player_state_engine_pkg;

   // Width defaults
   localparam int unsigned DefStateDepth       = 3;
   localparam int unsigned DefInputDepth       = 5;
   localparam int unsigned DefSpriteIndexDepth = 4;

   // Button bit positions within player_buttons
   localparam int unsigned BtnForwards  = 0;
   localparam int unsigned BtnBackwards = 1;
   localparam int unsigned BtnGrab      = 2;
   localparam int unsigned BtnBlock     = 3;
   localparam int unsigned BtnKick      = 4;

   typedef enum logic [2:0] {
      StNothing   = 3'd0,
      StForwards  = 3'd1,
      StBackwards = 3'd2,
      StGrab      = 3'd3,
      StBlock     = 3'd4,
      StKick      = 3'd5,
      StWin       = 3'd6,
      StLose      = 3'd7
   } state_e;

   // Button priority: KICK > BLOCK > GRAB > BACKWARDS > FORWARDS, else idle.
   function automatic state_e pick_action(logic [BtnKick:0] btn);
      state_e st;
      st = StNothing;
      if (btn[BtnKick])           st = StKick;
      else if (btn[BtnBlock])     st = StBlock;
      else if (btn[BtnGrab])      st = StGrab;
      else if (btn[BtnBackwards]) st = StBackwards;
      else if (btn[BtnForwards])  st = StForwards;
      return st;
   endfunction

endpackage

// File: rtl/player_input_latch.sv
// OR-latches button levels and hit-connection pulses between game frames.
// The tick_* outputs present everything seen since the last tick, including
// the current cycle, so an input raised in the tick cycle itself counts.
// All latches clear on a tick; nothing carries over to the following frame.
//
// Ports:
//   sys_clk, reset            clock, synchronous active-high reset
//   frame_tick                one-cycle strobe per game frame
//   player_buttons            button levels
//   player_attack_connected   our hit landed (pulse)
//   opponent_attack_connected opponent hit landed (pulse)
//   tick_buttons              buttons seen this frame
//   tick_player_hit           our hit seen this frame
//   tick_opponent_hit         opponent hit seen this frame
module player_input_latch #(
   parameter int unsigned INPUT_DEPTH = 5
) (
   input  logic                   sys_clk,
   input  logic                   reset,
   input  logic                   frame_tick,
   input  logic [INPUT_DEPTH-1:0] player_buttons,
   input  logic                   player_attack_connected,
   input  logic                   opponent_attack_connected,
   output logic [INPUT_DEPTH-1:0] tick_buttons,
   output logic                   tick_player_hit,
   output logic                   tick_opponent_hit
);

   logic [INPUT_DEPTH-1:0] pending_q, pending_d;
   logic                   p_hit_q, p_hit_d;
   logic                   o_hit_q, o_hit_d;

   always_comb begin
      tick_buttons      = pending_q | player_buttons;
      tick_player_hit   = p_hit_q | player_attack_connected;
      tick_opponent_hit = o_hit_q | opponent_attack_connected;

      pending_d = frame_tick ? '0   : tick_buttons;
      p_hit_d   = frame_tick ? 1'b0 : tick_player_hit;
      o_hit_d   = frame_tick ? 1'b0 : tick_opponent_hit;
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         pending_q <= '0;
         p_hit_q   <= 1'b0;
         o_hit_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         p_hit_q   <= p_hit_d;
         o_hit_q   <= o_hit_d;
      end
   end

endmodule

// File: rtl/player_state_engine.sv
// Per-player fighting-state machine, advanced once per game frame.
// Resolves win/lose, then action priority when actionable, and times each
// action with a frame counter. All outputs are registered and are computed
// from the next state, so they update on the edge that samples frame_tick.
//
// Ports:
//   sys_clk, reset            clock, synchronous active-high reset
//   frame_tick                one-cycle strobe per game frame
//   player_buttons            button levels (FWD, BACK, GRAB, BLOCK, KICK)
//   player_attack_connected   our hit landed (pulse)
//   opponent_attack_connected opponent hit landed (pulse)
//   player_state              current state code
//   frame_count               frames elapsed in current state
//   sprite_index              animation frame
//   actionable                next tick accepts a new action
//   attack_active             kick or grab in its active window
module player_state_engine
   import player_state_engine_pkg::*;
#(
   parameter int unsigned INPUT_DEPTH        = DefInputDepth,
   parameter int unsigned STATE_DEPTH        = DefStateDepth,
   parameter int unsigned SPRITE_INDEX_DEPTH = DefSpriteIndexDepth,
   parameter int unsigned FRAME_CNT_DEPTH    = 5,
   parameter int unsigned ANIM_SHIFT         = 1,
   parameter int unsigned KICK_STARTUP       = 3,
   parameter int unsigned KICK_ACTIVE        = 2,
   parameter int unsigned KICK_RECOVERY      = 5,
   parameter int unsigned GRAB_STARTUP       = 2,
   parameter int unsigned GRAB_ACTIVE        = 1,
   parameter int unsigned GRAB_RECOVERY      = 6,
   parameter int unsigned BLOCK_FRAMES       = 6,
   parameter int unsigned MOVE_FRAMES        = 4
) (
   input  logic                          sys_clk,
   input  logic                          reset,
   input  logic                          frame_tick,
   input  logic [INPUT_DEPTH-1:0]        player_buttons,
   input  logic                          player_attack_connected,
   input  logic                          opponent_attack_connected,
   output logic [STATE_DEPTH-1:0]        player_state,
   output logic [FRAME_CNT_DEPTH-1:0]    frame_count,
   output logic [SPRITE_INDEX_DEPTH-1:0] sprite_index,
   output logic                          actionable,
   output logic                          attack_active
);

   localparam int unsigned FcW        = FRAME_CNT_DEPTH;
   localparam int unsigned KickFrames = KICK_STARTUP + KICK_ACTIVE + KICK_RECOVERY;
   localparam int unsigned GrabFrames = GRAB_STARTUP + GRAB_ACTIVE + GRAB_RECOVERY;
   localparam int unsigned SpriteMax  = (2 ** SPRITE_INDEX_DEPTH) - 1;

   // Last frame of each action; the player may act again on the next tick.
   localparam logic [FcW-1:0] KickLast  = FcW'(KickFrames - 1);
   localparam logic [FcW-1:0] GrabLast  = FcW'(GrabFrames - 1);
   localparam logic [FcW-1:0] BlockLast = FcW'(BLOCK_FRAMES - 1);
   localparam logic [FcW-1:0] MoveLast  = FcW'(MOVE_FRAMES - 1);

   // Active windows, one bit wider so the end bound may equal 2^FcW.
   localparam logic [FcW:0] KickWinLo = (FcW + 1)'(KICK_STARTUP);
   localparam logic [FcW:0] KickWinHi = (FcW + 1)'(KICK_STARTUP + KICK_ACTIVE);
   localparam logic [FcW:0] GrabWinLo = (FcW + 1)'(GRAB_STARTUP);
   localparam logic [FcW:0] GrabWinHi = (FcW + 1)'(GRAB_STARTUP + GRAB_ACTIVE);

   logic [INPUT_DEPTH-1:0] tick_buttons;
   logic                   tick_player_hit;
   logic                   tick_opponent_hit;

   player_input_latch #(
      .INPUT_DEPTH (INPUT_DEPTH)
   ) u_input_latch (
      .sys_clk                   (sys_clk),
      .reset                     (reset),
      .frame_tick                (frame_tick),
      .player_buttons            (player_buttons),
      .player_attack_connected   (player_attack_connected),
      .opponent_attack_connected (opponent_attack_connected),
      .tick_buttons              (tick_buttons),
      .tick_player_hit           (tick_player_hit),
      .tick_opponent_hit         (tick_opponent_hit)
   );

   state_e                        state_q, state_d;
   logic [FcW-1:0]                frame_q, frame_d;
   logic [SPRITE_INDEX_DEPTH-1:0] sprite_q, sprite_d;
   logic                          actionable_q, actionable_d;
   logic                          attack_q, attack_d;

   state_e                        chosen;
   logic [FcW-1:0]                last_frame;
   logic                          is_action;
   logic [FcW-1:0]                anim_step;
   logic [FcW:0]                  frame_ext;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      chosen  = pick_action(tick_buttons[BtnKick:0]);

      if (frame_tick) begin
         if (state_q == StWin || state_q == StLose) begin
            // Terminal until reset; counter parks at its maximum.
            if (frame_q != '1) frame_d = frame_q + 1'b1;
         end else if (tick_player_hit) begin
            state_d = StWin;
            frame_d = '0;
         end else if (tick_opponent_hit) begin
            state_d = StLose;
            frame_d = '0;
         end else if (actionable_q) begin
            state_d = chosen;
            // Idle loop counts up and wraps; any action (re)starts at 0.
            if (chosen == StNothing && state_q == StNothing) frame_d = frame_q + 1'b1;
            else                                             frame_d = '0;
         end else begin
            frame_d = frame_q + 1'b1;
         end
      end
   end

   // Output decode from the next state so outputs can be registered
   always_comb begin
      last_frame = '0;
      is_action  = 1'b1;
      unique case (state_d)
         StKick:                  last_frame = KickLast;
         StGrab:                  last_frame = GrabLast;
         StBlock:                 last_frame = BlockLast;
         StForwards, StBackwards: last_frame = MoveLast;
         default:                 is_action  = 1'b0;
      endcase

      actionable_d = (state_d == StNothing) || (is_action && frame_d == last_frame);

      frame_ext = {1'b0, frame_d};
      attack_d  = ((state_d == StKick) && frame_ext >= KickWinLo && frame_ext < KickWinHi) ||
                  ((state_d == StGrab) && frame_ext >= GrabWinLo && frame_ext < GrabWinHi);

      anim_step = frame_d >> ANIM_SHIFT;
      if (32'(anim_step) > SpriteMax) sprite_d = '1;
      else                            sprite_d = SPRITE_INDEX_DEPTH'(anim_step);
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q      <= StNothing;
         frame_q      <= '0;
         sprite_q     <= '0;
         actionable_q <= 1'b1;
         attack_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_q      <= frame_d;
         sprite_q     <= sprite_d;
         actionable_q <= actionable_d;
         attack_q     <= attack_d;
      end
   end

   assign player_state  = STATE_DEPTH'(state_q);
   assign frame_count   = frame_q;
   assign sprite_index  = sprite_q;
   assign actionable    = actionable_q;
   assign attack_active = attack_q;

endmodule
